// File: rtl/cache_line_fill_ctrl_pkg.sv
// ============================================================================
// cache_pkg : shared types and constants for the cache line-fill controller
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fill_state_t;

  // Ceiling log2, usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_line_fill_ctrl_line_word_counter.sv
// ============================================================================
// line_word_counter : counts words of a line, reports wrapped offset and end
// Rev 1.0
// ============================================================================
`default_nettype none

module line_word_counter
  import cache_pkg::*;
#(
  parameter  int WORDS = DEF_WORDS,
  localparam int OFF_W = clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [OFF_W-1:0] start_off,
  output logic [OFF_W-1:0] off,
  output logic             done,
  output logic             last
);

  localparam int CNT_W = OFF_W + 1;

  // One extra bit so that a full count of WORDS is distinguishable from 0.
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CNT_W'(1);
    end
  end

  assign off  = start_off + count[OFF_W-1:0];
  assign done = (count == CNT_W'(WORDS));
  assign last = (count == CNT_W'(WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/cache_line_fill_ctrl.sv
// ============================================================================
// cache_line_fill_ctrl : cache-miss line-fill controller (issue, fill, commit)
// Optional critical-word-first ordering when CACHE_FILL_CWF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int WORDS  = DEF_WORDS,
  localparam int OFF_W  = clog2(WORDS),
  localparam int BYTE_W = clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  output logic              write_data_array,
  output logic [DATA_W-1:0] cache_array_data,
  output logic [OFF_W-1:0]  cache_word,
  output logic              write_tag_array,
  output logic              write_valid_bit,
  output logic              critical_word_valid
);

  localparam int LINE_W = ADDR_W - OFF_W - BYTE_W;

  fill_state_t       state;
  fill_state_t       state_next;
  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  start_off_q;
  logic [OFF_W-1:0]  start_off_d;
  logic              miss_accept;

  logic              issue_en;
  logic [OFF_W-1:0]  issue_off;
  logic              issue_done;
  logic              issue_last;
  logic              fill_en;
  logic [OFF_W-1:0]  fill_off;
  logic              fill_done;
  logic              fill_last;

  // Byte-offset bits (and word-offset bits in linear mode) carry no meaning here.
  logic              unused_miss_bits;
  assign unused_miss_bits = ^miss_address;

`ifdef CACHE_FILL_CWF_EN
  assign start_off_d = miss_address[OFF_W+BYTE_W-1:BYTE_W];
`else
  assign start_off_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      line_q      <= '0;
      start_off_q <= '0;
    end else begin
      state <= state_next;
      if (miss_accept) begin
        line_q      <= miss_address[ADDR_W-1:OFF_W+BYTE_W];
        start_off_q <= start_off_d;
      end
    end
  end

  always_comb begin
    state_next          = state;
    miss_accept         = 1'b0;
    mem_req             = 1'b0;
    write_data_array    = 1'b0;
    write_tag_array     = 1'b0;
    write_valid_bit     = 1'b0;
    critical_word_valid = 1'b0;
    cache_array_data    = '0;
    cache_word          = '0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          miss_accept = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = !issue_done;
        if (mem_req && mem_grant && issue_last) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Returns are accepted in ISSUE and WAIT alike; the last one commits the line
    // and wins over any ISSUE->WAIT transition computed above.
    if (state != IDLE && mem_data_valid && !fill_done) begin
      write_data_array    = 1'b1;
      cache_array_data    = mem_data;
      cache_word          = fill_off;
      critical_word_valid = (fill_off == start_off_q);
      if (fill_last) begin
        write_tag_array = 1'b1;
        write_valid_bit = 1'b1;
        state_next      = IDLE;
      end
    end

    // A reset cycle must never commit a partial line or launch a request.
    if (rst) begin
      mem_req             = 1'b0;
      write_data_array    = 1'b0;
      write_tag_array     = 1'b0;
      write_valid_bit     = 1'b0;
      critical_word_valid = 1'b0;
      cache_array_data    = '0;
      cache_word          = '0;
    end
  end

  assign issue_en    = mem_req && mem_grant;
  assign fill_en     = write_data_array;
  assign fsm_busy    = (state != IDLE);
  assign mem_address = ADDR_W'({line_q, issue_off}) << BYTE_W;

  line_word_counter #(
    .WORDS     (WORDS)
  ) u_issue_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (miss_accept),
    .enable    (issue_en),
    .start_off (start_off_q),
    .off       (issue_off),
    .done      (issue_done),
    .last      (issue_last)
  );

  line_word_counter #(
    .WORDS     (WORDS)
  ) u_fill_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (miss_accept),
    .enable    (fill_en),
    .start_off (start_off_q),
    .off       (fill_off),
    .done      (fill_done),
    .last      (fill_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_line_fill_ctrl.sv
// ============================================================================
// tb_cache_line_fill_ctrl : self-checking bench for cache_line_fill_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_line_fill_ctrl;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        mem_grant = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        fsm_busy, mem_req, write_data_array, write_tag_array;
  logic        write_valid_bit, critical_word_valid;
  logic [15:0] mem_address, cache_array_data;
  logic [2:0]  cache_word;

  logic        b_miss = 1'b0;
  logic [31:0] b_miss_addr = '0;
  logic        b_grant = 1'b0;
  logic        b_valid = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_busy, b_req, b_wr, b_tag, b_vld, b_cwv;
  logic [31:0] b_addr, b_wdata;
  logic [1:0]  b_word;

  always #5 clk = ~clk;

  cache_line_fill_ctrl u_dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_grant(mem_grant), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fsm_busy(fsm_busy), .mem_req(mem_req), .mem_address(mem_address),
    .write_data_array(write_data_array), .cache_array_data(cache_array_data),
    .cache_word(cache_word), .write_tag_array(write_tag_array),
    .write_valid_bit(write_valid_bit), .critical_word_valid(critical_word_valid)
  );

  cache_line_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4)) u_dut_b (
    .clk(clk), .rst(rst), .miss_detected(b_miss), .miss_address(b_miss_addr),
    .mem_grant(b_grant), .mem_data_valid(b_valid), .mem_data(b_data),
    .fsm_busy(b_busy), .mem_req(b_req), .mem_address(b_addr),
    .write_data_array(b_wr), .cache_array_data(b_wdata),
    .cache_word(b_word), .write_tag_array(b_tag),
    .write_valid_bit(b_vld), .critical_word_valid(b_cwv)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a line is a list of word offsets ----------------
  typedef struct {
    int          ready;
    logic [15:0] data;
  } ret_t;

  bit          m_busy = 1'b0;
  logic [15:0] issue_q[$];
  int          fill_q[$];
  int          fill_cnt = 0;
  ret_t        pend[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_writes, n_tag, n_busy, first_word;
  logic [15:0] first_addr;
  bit          got_first_addr;

  function automatic int start_of(input logic [15:0] a);
`ifdef CACHE_FILL_CWF_EN
    return (int'(a) / 2) % WORDS;
`else
    return 0;
`endif
  endfunction

  task automatic model_load(input logic [15:0] a);
    int base;
    int st;
    base = int'(a) - (int'(a) % (WORDS * 2));
    st   = start_of(a);
    issue_q.delete();
    fill_q.delete();
    for (int k = 0; k < WORDS; k++) begin
      issue_q.push_back(16'(base + ((st + k) % WORDS) * 2));
      fill_q.push_back((st + k) % WORDS);
    end
    fill_cnt = 0;
    m_busy   = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 ns later, advance the model.
  task automatic tick(input bit grant, input bit miss, input logic [15:0] maddr, input bit rin);
    bit   exp_req, exp_wr, exp_last, exp_cwv;
    ret_t r;
    @(negedge clk);
    rst           = rin;
    miss_detected = miss;
    miss_address  = maddr;
    mem_grant     = grant;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'($urandom);
    end
    #1;
    chk("busy", fsm_busy, m_busy);
    exp_req = m_busy && (issue_q.size() > 0) && !rin;
    chk("mem_req", mem_req, exp_req);
    if (exp_req) begin
      chk("mem_address", mem_address, issue_q[0]);
      if (grant) begin
        r.ready = cyc + lat;
        r.data  = issue_q[0] ^ 16'h5A5A;
        pend.push_back(r);
        void'(issue_q.pop_front());
      end
    end
    exp_wr = m_busy && mem_data_valid && !rin;
    chk("write_data", write_data_array, exp_wr);
    exp_last = 1'b0;
    exp_cwv  = 1'b0;
    if (exp_wr) begin
      chk("cache_word", cache_word, fill_q[0]);
      chk("cache_data", cache_array_data, mem_data);
      exp_last = (fill_q.size() == 1);
      exp_cwv  = (fill_cnt == 0);
    end
    chk("tag_write", write_tag_array, exp_last);
    chk("valid_write", write_valid_bit, exp_last);
    chk("crit_word", critical_word_valid, exp_cwv);
    if (write_data_array) n_writes++;
    if (write_tag_array) n_tag++;
    if (fsm_busy) n_busy++;
    if (critical_word_valid) first_word = int'(cache_word);
    if (mem_req && !got_first_addr) begin
      first_addr     = mem_address;
      got_first_addr = 1'b1;
    end
    if (rin) begin
      m_busy = 1'b0;
      issue_q.delete();
      fill_q.delete();
    end else if (!m_busy && miss) begin
      model_load(maddr);
    end else if (exp_wr) begin
      void'(fill_q.pop_front());
      fill_cnt++;
      if (fill_q.size() == 0) m_busy = 1'b0;
    end
    cyc++;
  endtask

  // gmode: 0 grant always, 1 grant toggles, 2 random grant
  task automatic run_fill(input logic [15:0] a, input int gmode, input int l, input bit hold);
    bit g;
    int guard;
    lat            = l;
    n_writes       = 0;
    n_tag          = 0;
    n_busy         = 0;
    first_word     = -1;
    got_first_addr = 1'b0;
    g              = 1'b1;
    tick(1'b1, 1'b1, a, 1'b0);
    guard = 0;
    while (m_busy && guard < 200) begin
      if (gmode == 1) g = ~g;
      else if (gmode == 2) g = 1'($urandom_range(0, 1));
      else g = 1'b1;
      tick(g, hold, hold ? 16'hABCD : a, 1'b0);
      guard++;
    end
    chk("fill_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          gmode;
    int          lat;
    bit          hold;
    int          exp_first_word;
    logic [15:0] exp_first_addr;
    int          exp_busy;
    int          exp_writes;
  } vec_t;

  vec_t vecs[5];

  logic [31:0] b_exp_addr[4];
  int          b_exp_word[4];
  logic [31:0] b_got_addr[4];
  int          b_got_word[4];

  initial begin
    int          nb_req, nb_wr, nb_tag;
    bit          b_prev_acc;
    logic [31:0] b_prev_addr;

`ifdef CACHE_FILL_CWF_EN
    vecs[0] = '{16'h1236, 0, 1, 1'b0, 3, 16'h1236, 9, 8};
    vecs[1] = '{16'h123A, 0, 1, 1'b0, 5, 16'h123A, 9, 8};
    vecs[3] = '{16'h125E, 0, 2, 1'b1, 7, 16'h125E, 10, 8};
    b_exp_addr = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    b_exp_word = '{2, 3, 0, 1};
`else
    vecs[0] = '{16'h1236, 0, 1, 1'b0, 0, 16'h1230, 9, 8};
    vecs[1] = '{16'h123A, 0, 1, 1'b0, 0, 16'h1230, 9, 8};
    vecs[3] = '{16'h125E, 0, 2, 1'b1, 0, 16'h1250, 10, 8};
    b_exp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    b_exp_word = '{0, 1, 2, 3};
`endif
    vecs[2] = '{16'h1230, 1, 3, 1'b0, 0, 16'h1230, -1, 8};
    vecs[4] = '{16'h8000, 0, 1, 1'b0, 0, 16'h8000, 9, 8};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wr", write_data_array, 0);
    chk("rst_tag", write_tag_array, 0);
    chk("rst_valid", write_valid_bit, 0);
    chk("rst_cwv", critical_word_valid, 0);
    chk("rst_word", cache_word, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;

    // Table vectors, back to back (vector 3 holds miss high, vector 4 follows at once)
    for (int i = 0; i < 5; i++) begin
      run_fill(vecs[i].addr, vecs[i].gmode, vecs[i].lat, vecs[i].hold);
      chk($sformatf("v%0d_writes", i), n_writes, vecs[i].exp_writes);
      chk($sformatf("v%0d_tags", i), n_tag, 1);
      chk($sformatf("v%0d_first_word", i), first_word, vecs[i].exp_first_word);
      chk($sformatf("v%0d_first_addr", i), first_addr, vecs[i].exp_first_addr);
      if (vecs[i].exp_busy >= 0) chk($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].exp_busy);
    end

    // Reset after the 4th return; the remaining 4 returns must be dropped
    begin
      int guard;
      lat = 5;
      tick(1'b1, 1'b1, 16'h1240, 1'b0);
      guard = 0;
      while (fill_cnt < 4 && guard < 100) begin
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        guard++;
      end
      chk("rst_mid_reached", fill_cnt, 4);
      n_writes = 0;
      n_tag    = 0;
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      repeat (6) tick(1'b1, 1'b0, 16'h0, 1'b0);
      chk("rst_mid_writes", n_writes, 0);
      chk("rst_mid_tags", n_tag, 0);
      chk("rst_mid_drained", pend.size(), 0);
    end

    // Randomized fills against the model
    for (int i = 0; i < 25; i++) begin
      run_fill(16'($urandom), 2, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      chk($sformatf("rnd%0d_writes", i), n_writes, 8);
      chk($sformatf("rnd%0d_tags", i), n_tag, 1);
    end

    // Second configuration: 4 words of 32 bits, 32-bit addresses
    nb_req     = 0;
    nb_wr      = 0;
    nb_tag     = 0;
    b_prev_acc = 1'b0;
    b_prev_addr = '0;
    @(negedge clk);
    b_miss      = 1'b1;
    b_miss_addr = 32'h0000_1008;
    b_grant     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b_miss  = 1'b0;
      b_valid = b_prev_acc;
      b_data  = b_prev_addr ^ 32'hDEAD_BEEF;
      #1;
      b_prev_acc = 1'b0;
      if (b_req) begin
        if (nb_req < 4) b_got_addr[nb_req] = b_addr;
        nb_req++;
        b_prev_acc  = 1'b1;
        b_prev_addr = b_addr;
      end
      if (b_wr) begin
        if (nb_wr < 4) b_got_word[nb_wr] = int'(b_word);
        chk("b_data", b_wdata, b_data);
        nb_wr++;
      end
      if (b_tag) begin
        nb_tag++;
        chk("b_tag_on_last", nb_wr, 4);
      end
    end
    chk("b_reqs", nb_req, 4);
    chk("b_writes", nb_wr, 4);
    chk("b_tags", nb_tag, 1);
    chk("b_idle", b_busy, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b_addr%0d", k), (k < nb_req) ? b_got_addr[k] : 32'hFFFF_FFFF, b_exp_addr[k]);
      chk($sformatf("b_word%0d", k), (k < nb_wr) ? b_got_word[k] : -1, b_exp_word[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
